cond_flag_unit: RTL and testbench

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

---
 rtl/cond_flag_unit.sv | 112 +++++++++++
 tb/tb_cond_flag_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : ARM-style condition evaluation and NZCV flag register.
//               Evaluates the condition field of each accepted instruction
//               against the stored flags. It conditionally loads new flags
//               from the ALU and keeps a saturating count of instructions
//               whose condition failed.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       s_en,
    input  logic [3:0] cond,
    input  logic       instr_valid,
    input  logic       stall,
    output logic [3:0] flags,
    output logic       cin,
    output logic       cond_pass,
    output logic       out_valid,
    output logic [7:0] fail_cnt
);

    localparam logic [7:0] FAIL_CNT_MAX = 8'hFF;

    // Condition codes
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;

    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_ok;
    logic       accept;
    logic [3:0] alu_flags;

    assign flag_n    = flags[3];
    assign flag_z    = flags[2];
    assign flag_c    = flags[1];
    assign flag_v    = flags[0];
    assign accept    = instr_valid & ~stall;
    assign alu_flags = {alu_n, alu_z, alu_co, alu_v};

    // Carry-in for the ALU comes straight from the stored C flag
    assign cin = flags[1];

    // Evaluate the condition against the stored (pre-update) flags only
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            CC_EQ:   cond_ok = flag_z;
            CC_NE:   cond_ok = ~flag_z;
            CC_CS:   cond_ok = flag_c;
            CC_CC:   cond_ok = ~flag_c;
            CC_MI:   cond_ok = flag_n;
            CC_PL:   cond_ok = ~flag_n;
            CC_VS:   cond_ok = flag_v;
            CC_VC:   cond_ok = ~flag_v;
            CC_HI:   cond_ok = flag_c & ~flag_z;
            CC_LS:   cond_ok = ~flag_c | flag_z;
            CC_GE:   cond_ok = (flag_n == flag_v);
            CC_LT:   cond_ok = (flag_n != flag_v);
            CC_GT:   cond_ok = ~flag_z & (flag_n == flag_v);
            CC_LE:   cond_ok = flag_z | (flag_n != flag_v);
            CC_AL:   cond_ok = 1'b1;
            default: cond_ok = 1'b0;   // NV never executes
        endcase
    end

    // Flag register, registered condition result and failure counter
    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= 4'b0000;
            cond_pass <= 1'b0;
            out_valid <= 1'b0;
            fail_cnt  <= 8'd0;
        end else if (!stall) begin
            out_valid <= instr_valid;
            if (accept) begin
                cond_pass <= cond_ok;
                if (cond_ok) begin
                    if (s_en) begin
                        flags <= alu_flags;
                    end
                end else if (fail_cnt != FAIL_CNT_MAX) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_flag_unit
// Description : Self-checking bench for cond_flag_unit. It applies a vector
//               table, a saturation sequence and random traffic checked
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_n, alu_z, alu_co, alu_v;
    logic       s_en;
    logic [3:0] cond;
    logic       instr_valid;
    logic       stall;
    logic [3:0] flags;
    logic       cin;
    logic       cond_pass;
    logic       out_valid;
    logic [7:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    cond_flag_unit dut (
        .clk         (clk),
        .reset       (reset),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_co      (alu_co),
        .alu_v       (alu_v),
        .s_en        (s_en),
        .cond        (cond),
        .instr_valid (instr_valid),
        .stall       (stall),
        .flags       (flags),
        .cin         (cin),
        .cond_pass   (cond_pass),
        .out_valid   (out_valid),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic       st;
        logic       se;
        logic [3:0] cc;
        logic [3:0] alu;
        logic [3:0] e_flags;
        logic       e_pass;
        logic       e_valid;
        logic [7:0] e_fail;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [3:0] m_flags;
    logic       m_pass;
    logic       m_valid;
    int         m_fail;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // ARM condition semantics: the upper three bits select a predicate,
    // the low bit inverts it (1110 AL / 1111 NV fall out naturally).
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic drive(input logic r, input logic iv, input logic st, input logic se,
                         input logic [3:0] cc, input logic [3:0] alu);
        reset = r; instr_valid = iv; stall = st; s_en = se; cond = cc;
        {alu_n, alu_z, alu_co, alu_v} = alu;
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        logic ok;
        if (reset) begin
            m_flags = 4'b0; m_pass = 1'b0; m_valid = 1'b0; m_fail = 0;
        end else if (!stall) begin
            m_valid = instr_valid;
            if (instr_valid) begin
                ok = ref_cond(cond, m_flags);
                m_pass = ok;
                if (ok && s_en) m_flags = {alu_n, alu_z, alu_co, alu_v};
                if (!ok && m_fail < 255) m_fail = m_fail + 1;
            end
        end
    endtask

    task automatic model_cycle_check(input string tag, input int row);
        model_step();
        @(posedge clk); #1;
        chk({tag, ".flags"}, row, flags, m_flags);
        chk({tag, ".cin"}, row, cin, m_flags[1]);
        chk({tag, ".pass"}, row, cond_pass, m_pass);
        chk({tag, ".valid"}, row, out_valid, m_valid);
        chk({tag, ".fail_cnt"}, row, fail_cnt, m_fail);
    endtask

    initial begin
        //                rst  iv   st   se   cond     alu      flags    pass valid fail
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0,8'd0}); // reset
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1110,4'b1001,4'b1001,1'b1,1'b1,8'd0}); // AL load 1001
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b0000,4'b1111,4'b1001,1'b0,1'b1,8'd1}); // EQ fails
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1110,4'b0100,4'b0100,1'b1,1'b1,8'd1}); // flags=0100
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b0000,4'b0010,4'b0010,1'b1,1'b1,8'd1}); // EQ pass, load
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b0000,4'b0100,4'b0010,1'b0,1'b1,8'd2}); // EQ now fails
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0000,4'b0010,1'b0,1'b0,8'd2}); // idle
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1110,4'b1000,4'b1000,1'b1,1'b1,8'd2}); // flags=1000
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'b1011,4'b0000,4'b1000,1'b1,1'b1,8'd2}); // LT pass
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'b1010,4'b0000,4'b1000,1'b0,1'b1,8'd3}); // GE fail
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'b1100,4'b0000,4'b1000,1'b0,1'b1,8'd4}); // GT fail
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1110,4'b1001,4'b1001,1'b1,1'b1,8'd4}); // flags=1001
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'b1100,4'b0000,4'b1001,1'b1,1'b1,8'd4}); // GT pass
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0000,4'b1001,1'b1,1'b0,8'd4}); // idle, pass holds
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'b1111,4'b0000,4'b1001,1'b1,1'b0,8'd4}); // stall 1
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'b1111,4'b0000,4'b1001,1'b1,1'b0,8'd4}); // stall 2
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'b1111,4'b0000,4'b1001,1'b1,1'b0,8'd4}); // stall 3
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1111,4'b0000,4'b1001,1'b0,1'b1,8'd5}); // released once
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0000,4'b1001,1'b0,1'b0,8'd5}); // idle
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'b1110,4'b0000,4'b1001,1'b1,1'b1,8'd5}); // AL, no S
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,4'b0000,4'b0000,4'b1001,1'b1,1'b1,8'd5}); // stall holds valid
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'b1111,4'b1111,4'b1001,1'b1,1'b1,8'd5}); // stall holds
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'b1111,4'b1111,4'b0000,1'b0,1'b0,8'd0}); // reset wins
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1110,4'b0010,4'b0010,1'b1,1'b1,8'd0}); // C=1 -> cin=1
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b0011,4'b0000,4'b0010,1'b0,1'b1,8'd1}); // CC fail
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b0010,4'b0000,4'b0000,1'b1,1'b1,8'd1}); // CS pass, clear
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b0010,4'b1111,4'b0000,1'b0,1'b1,8'd2}); // CS sees new C=0
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1001,4'b0110,4'b0110,1'b1,1'b1,8'd2}); // LS pass (!C)
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1000,4'b1111,4'b0110,1'b0,1'b1,8'd3}); // HI fail (Z)
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,4'b1101,4'b1010,4'b1010,1'b1,1'b1,8'd3}); // LE pass (Z)

        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].st, vecs[i].se, vecs[i].cc, vecs[i].alu);
            @(posedge clk); #1;
            chk("tbl.flags", i, flags, vecs[i].e_flags);
            chk("tbl.cin", i, cin, vecs[i].e_flags[1]);
            chk("tbl.pass", i, cond_pass, vecs[i].e_pass);
            chk("tbl.valid", i, out_valid, vecs[i].e_valid);
            chk("tbl.fail_cnt", i, fail_cnt, vecs[i].e_fail);
        end

        // Saturation: 260 NV instructions after reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        model_cycle_check("sat_rst", 0);
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'($urandom));
            model_cycle_check("sat", i);
        end
        chk("sat.final_cnt", 260, fail_cnt, 32'd255);
        chk("sat.final_flags", 260, flags, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), 1'($urandom), 4'($urandom), 4'($urandom));
            model_cycle_check("rnd", i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
